// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Initiator side of the data-memory load/store path, placed between the CPU
// execute stage and the data-memory responder. It takes one request at a time,
// computes the effective address and checks alignment. It drives the responder
// handshake and extracts/extends sub-word load data. A byte or halfword store is
// done as read-modify-write: the word is read, the new lane is merged in, and the
// whole word is written back.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (req_ready high only in IDLE)
//   is_store, size, is_unsigned, base, offset, store_data, rd_addr
//                              request fields, latched on acceptance
//   wb_valid, wb_rd, wb_data   one-cycle load write-back
//   done, err                  one-cycle completion pulse (err with done)
//   mem_ld_en, mem_st_en       responder enables (never both high)
//   mem_addr, mem_wdata        responder word address / write word
//   mem_rdata, mem_ready       responder read word / completion
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int MEM_AW  = 10,   // word-address width (must be <= 29)
   parameter int TIMEOUT = 16    // wait cycles before aborting an access
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_store,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] base,
   input  logic [15:0] offset,
   input  logic [31:0] store_data,
   input  logic [3:0]  rd_addr,
   output logic        wb_valid,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        done,
   output logic        err,
   output logic        mem_ld_en,
   output logic        mem_st_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LD_WAIT,
      ST_WAIT,
      RESP
   } state_t;

   state_t state_reg, state_next;

   // Latched request
   logic [MEM_AW+1:0] ea_reg;       // only the bits that reach the responder
   logic [1:0]        size_reg;
   logic              store_reg;
   logic              unsigned_reg;
   logic [31:0]       sdata_reg;
   logic [3:0]        rd_reg;
   logic              err_reg;

   logic [31:0]       wdata_reg;
   logic [31:0]       ld_data_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic [31:0]       ea_calc;
   logic              misalign;
   logic              timeout_hit;
   logic              in_wait;
   logic              cnt_at_limit;

   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       ld_ext;
   logic [31:0]       merged;

   // Effective address wraps modulo 2^32. Bits above the word address are
   // discarded; the reduction below just keeps them out of lint's way.
   assign ea_calc = base + {{16{offset[15]}}, offset};

   logic unused_ea_hi;
   assign unused_ea_hi = ^ea_calc[31:MEM_AW+2];

   always_comb begin
      misalign = 1'b0;
      case (size)
         SZ_BYTE: misalign = 1'b0;
         SZ_HALF: misalign = ea_calc[0];
         SZ_WORD: misalign = (ea_calc[1:0] != 2'b00);
         default: misalign = 1'b1;     // size 11 is illegal
      endcase
   end

   assign in_wait      = (state_reg == LD_WAIT) || (state_reg == ST_WAIT);
   assign cnt_at_limit = (cnt_reg == CNT_LIMIT);

   // ---------------------------------------------------------------------------
   // Load extraction from the word currently presented by the responder
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_byte = 8'h00;
      case (ea_reg[1:0])
         2'd0:    rd_byte = mem_rdata[7:0];
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         default: rd_byte = mem_rdata[31:24];
      endcase
      rd_half = ea_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      ld_ext = mem_rdata;
      case (size_reg)
         SZ_BYTE: ld_ext = unsigned_reg ? {24'h0, rd_byte}
                                        : {{24{rd_byte[7]}}, rd_byte};
         SZ_HALF: ld_ext = unsigned_reg ? {16'h0, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
         default: ld_ext = mem_rdata;   // word: is_unsigned has no effect
      endcase
   end

   // ---------------------------------------------------------------------------
   // Read-modify-write merge, one byte lane per generate iteration. A byte
   // store hits exactly one lane; a half store hits the lane pair picked by
   // ea[1] and takes store_data byte 0 or 1 according to position in the pair.
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic byte_hit;
         logic half_hit;
         assign byte_hit = (size_reg == SZ_BYTE) && (ea_reg[1:0] == 2'(gi));
         assign half_hit = (size_reg == SZ_HALF) && (ea_reg[1] == 1'(gi / 2));
         assign merged[8*gi+7 -: 8] =
            byte_hit ? sdata_reg[7:0] :
            half_hit ? sdata_reg[8*(gi%2)+7 -: 8] :
                       mem_rdata[8*gi+7 -: 8];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and outputs. Enables are pure state decodes, so they fall
   // in the cycle after mem_ready is sampled and can never overlap.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      timeout_hit = 1'b0;
      req_ready   = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      wb_valid    = 1'b0;
      wb_rd       = 4'h0;
      wb_data     = 32'h0;
      mem_ld_en   = 1'b0;
      mem_st_en   = 1'b0;

      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = misalign ? RESP : SETUP;
            end
         end

         // Address is stable for one cycle before any enable rises.
         SETUP: begin
            if (store_reg && (size_reg == SZ_WORD)) begin
               state_next = ST_WAIT;
            end else begin
               state_next = LD_WAIT;
            end
         end

         LD_WAIT: begin
            mem_ld_en = 1'b1;
            if (mem_ready) begin
               state_next = store_reg ? ST_WAIT : RESP;
            end else if (cnt_at_limit) begin
               timeout_hit = 1'b1;
               state_next  = RESP;
            end
         end

         ST_WAIT: begin
            mem_st_en = 1'b1;
            if (mem_ready) begin
               state_next = RESP;
            end else if (cnt_at_limit) begin
               timeout_hit = 1'b1;
               state_next  = RESP;
            end
         end

         RESP: begin
            done       = 1'b1;
            err        = err_reg;
            state_next = IDLE;
            if (!store_reg && !err_reg) begin
               wb_valid = 1'b1;
               wb_rd    = rd_reg;
               wb_data  = ld_data_reg;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign mem_addr  = {{(32-MEM_AW){1'b0}}, ea_reg[MEM_AW+1:2]};
   assign mem_wdata = wdata_reg;

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         ea_reg       <= '0;
         size_reg     <= 2'b00;
         store_reg    <= 1'b0;
         unsigned_reg <= 1'b0;
         sdata_reg    <= 32'h0;
         rd_reg       <= 4'h0;
         err_reg      <= 1'b0;
         wdata_reg    <= 32'h0;
         ld_data_reg  <= 32'h0;
         cnt_reg      <= '0;
      end else begin
         if ((state_reg == IDLE) && req_valid) begin
            ea_reg       <= ea_calc[MEM_AW+1:0];
            size_reg     <= size;
            store_reg    <= is_store;
            unsigned_reg <= is_unsigned;
            sdata_reg    <= store_data;
            rd_reg       <= rd_addr;
            err_reg      <= misalign;
         end

         if ((state_reg == SETUP) && store_reg) begin
            wdata_reg <= sdata_reg;
         end

         if ((state_reg == LD_WAIT) && mem_ready) begin
            if (store_reg) begin
               wdata_reg <= merged;
            end else begin
               ld_data_reg <= ld_ext;
            end
         end

         if (timeout_hit) begin
            err_reg <= 1'b1;
         end

         // Restart on every entry into a wait state (including LD -> ST).
         if (in_wait && (state_next == state_reg)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end else begin
            cnt_reg <= '0;
         end
      end
   end

endmodule
